// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequencer for an iterative AES round datapath.
// Optional macro AES_CTRL_SIZE_ERR_EN adds the err output for size 11.
module aes_round_ctrl #(
    parameter int CYCLES_PER_ROUND = 1,
    parameter int RK_IDX_W         = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic                mode,
    input  logic [1:0]          size,
    input  logic                abort,
    output logic                dp_load,
    output logic                rnd_en,
    output logic                rnd_first,
    output logic                rnd_last,
    output logic [RK_IDX_W-1:0] rk_idx,
    output logic                busy,
`ifdef AES_CTRL_SIZE_ERR_EN
    output logic                err,
`endif
    output logic                done_valid,
    input  logic                done_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    localparam logic [1:0] CNT_LAST = 2'(CYCLES_PER_ROUND - 1);

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [RK_IDX_W-1:0] rnd_q, rnd_d;
    logic [RK_IDX_W-1:0] nr_q, nr_d;
    logic                mode_q, mode_d;
    logic                step;

    logic                start_ready_q, start_ready_d;
    logic                dp_load_q, dp_load_d;
    logic                rnd_en_q, rnd_en_d;
    logic                rnd_first_q, rnd_first_d;
    logic                rnd_last_q, rnd_last_d;
    logic [RK_IDX_W-1:0] rk_idx_q, rk_idx_d;
    logic                busy_q, busy_d;
    logic                done_valid_q, done_valid_d;
`ifdef AES_CTRL_SIZE_ERR_EN
    logic                err_q, err_d;
`endif

    // Next state, step counters and the registered output values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rnd_d     = rnd_q;
        nr_d      = nr_q;
        mode_d    = mode_q;
        dp_load_d = 1'b0;
`ifdef AES_CTRL_SIZE_ERR_EN
        err_d     = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    mode_d    = mode;
                    cnt_d     = '0;
                    rnd_d     = '0;
                    dp_load_d = 1'b1;
                    state_d   = S_INIT;
                    unique case (size)
                        2'b00:   nr_d = RK_IDX_W'(10);
                        2'b01:   nr_d = RK_IDX_W'(12);
                        default: nr_d = RK_IDX_W'(14);
                    endcase
`ifdef AES_CTRL_SIZE_ERR_EN
                    if (size == 2'b11) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
`endif
                end
            end
            S_INIT, S_ROUND, S_FINAL: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    rnd_d = rnd_q + 1'b1;
                    if (state_q == S_FINAL) begin
                        state_d = S_DONE;
                    end else if (rnd_d == nr_q) begin
                        state_d = S_FINAL;
                    end else begin
                        state_d = S_ROUND;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_DONE: begin
                if (abort || done_ready) begin
                    state_d = S_IDLE;
`ifdef AES_CTRL_SIZE_ERR_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        step = (state_d == S_INIT) || (state_d == S_ROUND) ||
               (state_d == S_FINAL);
        start_ready_d = (state_d == S_IDLE);
        busy_d        = (state_d != S_IDLE);
        done_valid_d  = (state_d == S_DONE);
        rnd_first_d   = (state_d == S_INIT);
        rnd_last_d    = (state_d == S_FINAL);
        rnd_en_d      = step && (cnt_d == CNT_LAST);
        rk_idx_d      = '0;
        if (step) begin
            rk_idx_d = mode_d ? (nr_d - rnd_d) : rnd_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            rnd_q         <= '0;
            nr_q          <= '0;
            mode_q        <= 1'b0;
            start_ready_q <= 1'b1;
            dp_load_q     <= 1'b0;
            rnd_en_q      <= 1'b0;
            rnd_first_q   <= 1'b0;
            rnd_last_q    <= 1'b0;
            rk_idx_q      <= '0;
            busy_q        <= 1'b0;
            done_valid_q  <= 1'b0;
`ifdef AES_CTRL_SIZE_ERR_EN
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rnd_q         <= rnd_d;
            nr_q          <= nr_d;
            mode_q        <= mode_d;
            start_ready_q <= start_ready_d;
            dp_load_q     <= dp_load_d;
            rnd_en_q      <= rnd_en_d;
            rnd_first_q   <= rnd_first_d;
            rnd_last_q    <= rnd_last_d;
            rk_idx_q      <= rk_idx_d;
            busy_q        <= busy_d;
            done_valid_q  <= done_valid_d;
`ifdef AES_CTRL_SIZE_ERR_EN
            err_q         <= err_d;
`endif
        end
    end

    assign start_ready = start_ready_q;
    assign dp_load     = dp_load_q;
    assign rnd_en      = rnd_en_q;
    assign rnd_first   = rnd_first_q;
    assign rnd_last    = rnd_last_q;
    assign rk_idx      = rk_idx_q;
    assign busy        = busy_q;
    assign done_valid  = done_valid_q;
`ifdef AES_CTRL_SIZE_ERR_EN
    assign err         = err_q;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: two controller instances (1 and 3 cycles per round)
// checked cycle by cycle against a step/latency model.
module tb_aes_round_ctrl;

`ifdef AES_CTRL_SIZE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       mode_i;
    logic [1:0] size_i;
    logic       sv[2];
    logic       dr[2];
    logic       ab[2];
    logic       sr[2];
    logic       dp[2];
    logic       en[2];
    logic       fi[2];
    logic       la[2];
    logic [3:0] idx[2];
    logic       bz[2];
    logic       dv[2];
    logic       er[2];

    int n_chk;
    int n_pass;

    aes_round_ctrl #(.CYCLES_PER_ROUND(1), .RK_IDX_W(4)) u_c1 (
        .clk(clk), .rst_n(rst_n),
        .start_valid(sv[0]), .start_ready(sr[0]),
        .mode(mode_i), .size(size_i), .abort(ab[0]),
        .dp_load(dp[0]), .rnd_en(en[0]),
        .rnd_first(fi[0]), .rnd_last(la[0]),
        .rk_idx(idx[0]), .busy(bz[0]),
`ifdef AES_CTRL_SIZE_ERR_EN
        .err(er[0]),
`endif
        .done_valid(dv[0]), .done_ready(dr[0])
    );

    aes_round_ctrl #(.CYCLES_PER_ROUND(3), .RK_IDX_W(4)) u_c3 (
        .clk(clk), .rst_n(rst_n),
        .start_valid(sv[1]), .start_ready(sr[1]),
        .mode(mode_i), .size(size_i), .abort(ab[1]),
        .dp_load(dp[1]), .rnd_en(en[1]),
        .rnd_first(fi[1]), .rnd_last(la[1]),
        .rk_idx(idx[1]), .busy(bz[1]),
`ifdef AES_CTRL_SIZE_ERR_EN
        .err(er[1]),
`endif
        .done_valid(dv[1]), .done_ready(dr[1])
    );

`ifndef AES_CTRL_SIZE_ERR_EN
    assign er[0] = 1'b0;
    assign er[1] = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         sel;
        bit         m;
        logic [1:0] sz;
        int         hold;
        int         pulses;
        int         lat;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {sr, busy, dp, en, first, last, dv, err, idx[3:0]}
    function automatic logic [11:0] obs(input int s);
        return {sr[s], bz[s], dp[s], en[s], fi[s], la[s],
                dv[s], er[s], idx[s]};
    endfunction

    function automatic int nr_of(input logic [1:0] sz);
        if (sz == 2'b11) return 14;
        return 10 + 2 * int'(sz);
    endfunction

    // Expected outputs t cycles after the accept edge.
    function automatic logic [11:0] exp_vec(input bit m, input int nr,
                                            input int c, input int t,
                                            input bit e, input int td);
        logic [11:0] v;
        int st;
        v = '0;
        v[10] = 1'b1;
        if (t == td) begin
            v[9] = e;
            v[5] = 1'b1;
            v[4] = e;
        end else begin
            st = (t - 1) / c;
            v[9] = (t == 1);
            v[8] = ((t - 1) % c) == (c - 1);
            v[7] = (st == 0);
            v[6] = (st == nr);
            v[3:0] = m ? 4'(nr - st) : 4'(st);
        end
        return v;
    endfunction

    task automatic accept(input int s, input bit m, input logic [1:0] sz);
        int k;
        k = 0;
        @(negedge clk);
        while (!sr[s] && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("accept_ready", 32'(sr[s]), 32'd1);
        mode_i = m;
        size_i = sz;
        sv[s] = 1'b1;
        @(posedge clk);
        #1;
        sv[s] = 1'b0;
        mode_i = 1'($urandom);
        size_i = 2'($urandom);
    endtask

    task automatic run_job(input int s, input bit m, input logic [1:0] sz,
                           input int hold, output int pulses,
                           output int lat);
        int c;
        int nr;
        int td;
        int k;
        bit e;
        logic [11:0] ov;
        logic [11:0] ev;
        c = (s == 0) ? 1 : 3;
        e = ERR_EN && (sz == 2'b11);
        nr = nr_of(sz);
        td = e ? 1 : (nr + 1) * c + 1;
        pulses = 0;
        lat = -1;
        accept(s, m, sz);
        for (int t = 1; t <= td; t++) begin
            @(negedge clk);
            ov = obs(s);
            if (ov[8]) pulses++;
            if (ov[5] && lat < 0) lat = t;
            ev = exp_vec(m, nr, c, t, e, td);
            if (t == td) ov[3:0] = 4'd0;
            chk($sformatf("step_s%0d_t%0d", s, t), 32'(ov), 32'(ev));
        end
        k = 0;
        while (!dv[s] && !sr[s] && k < 200) begin
            @(negedge clk);
            if (en[s]) pulses++;
            k++;
        end
        if (!dv[s]) begin
            chk("done_reached", 32'(dv[s]), 32'd1);
            return;
        end
        if (lat < 0) lat = td + k;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            sv[s] = 1'b1;
            @(negedge clk);
            chk("done_hold", {29'd0, sr[s], bz[s], dv[s]}, 32'b011);
        end
        @(posedge clk);
        #1;
        dr[s] = 1'b1;
        @(negedge clk);
        chk("done_hs", 32'(dv[s]), 32'd1);
        @(posedge clk);
        #1;
        dr[s] = 1'b0;
        sv[s] = 1'b0;
        @(negedge clk);
        chk("after_hs", {28'd0, sr[s], bz[s], dv[s], er[s]}, 32'b1000);
    endtask

    initial begin
        int p;
        int l;
        int dv_seen;
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        mode_i = 1'b0;
        size_i = 2'b00;
        for (int i = 0; i < 2; i++) begin
            sv[i] = 1'b0;
            dr[i] = 1'b0;
            ab[i] = 1'b0;
        end

        tbl[0] = '{0, 1'b0, 2'b00, 0, 11, 12};
        tbl[1] = '{0, 1'b1, 2'b10, 5, 15, 16};
        tbl[2] = '{1, 1'b0, 2'b01, 0, 13, 40};
        tbl[3] = '{0, 1'b0, 2'b11, 1,
                   ERR_EN ? 0 : 15, ERR_EN ? 1 : 16};
        tbl[4] = '{1, 1'b1, 2'b00, 2, 11, 34};

        repeat (2) @(negedge clk);
        chk("reset_c1", 32'(obs(0)), 32'h800);
        chk("reset_c3", 32'(obs(1)), 32'h800);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_job(tbl[i].sel, tbl[i].m, tbl[i].sz, tbl[i].hold, p, l);
            chk($sformatf("tbl%0d_pulses", i), 32'(p), 32'(tbl[i].pulses));
            chk($sformatf("tbl%0d_lat", i), 32'(l), 32'(tbl[i].lat));
        end

        // Abort at rk_idx 4 of a 128-bit encrypt.
        accept(0, 1'b0, 2'b00);
        p = 0;
        dv_seen = 0;
        for (int t = 1; t <= 4; t++) begin
            @(negedge clk);
            if (en[0]) p++;
        end
        @(posedge clk);
        #1;
        ab[0] = 1'b1;
        @(negedge clk);
        if (en[0]) p++;
        chk("abort_idx", {27'd0, en[0], idx[0]}, 32'h14);
        @(posedge clk);
        #1;
        ab[0] = 1'b0;
        for (int t = 0; t < 14; t++) begin
            @(negedge clk);
            if (en[0]) p++;
            if (dv[0]) dv_seen++;
            chk("abort_idle", {29'd0, sr[0], bz[0], dv[0]}, 32'b100);
        end
        chk("abort_pulses", 32'(p), 32'd5);
        chk("abort_no_done", 32'(dv_seen), 32'd0);

        // Abort in DONE wins over done_ready.
        accept(0, 1'b0, 2'b00);
        repeat (12) @(negedge clk);
        chk("pre_abort_done", 32'(dv[0]), 32'd1);
        @(posedge clk);
        #1;
        ab[0] = 1'b1;
        dr[0] = 1'b1;
        @(posedge clk);
        #1;
        ab[0] = 1'b0;
        dr[0] = 1'b0;
        @(negedge clk);
        chk("abort_done", {29'd0, sr[0], bz[0], dv[0]}, 32'b100);

        // Asynchronous reset in the middle of a job.
        accept(1, 1'b1, 2'b10);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_c3", 32'(obs(1)), 32'h800);
        chk("midrst_c1", 32'(obs(0)), 32'h800);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            int s;
            bit m;
            logic [1:0] sz;
            int nr;
            bit e;
            s = int'($urandom_range(1, 0));
            m = 1'($urandom);
            sz = 2'($urandom);
            e = ERR_EN && (sz == 2'b11);
            nr = nr_of(sz);
            run_job(s, m, sz, int'($urandom_range(3, 0)), p, l);
            chk("rnd_pulses", 32'(p), e ? 32'd0 : 32'(nr + 1));
            chk("rnd_lat", 32'(l),
                e ? 32'd1 : 32'((nr + 1) * (s == 0 ? 1 : 3) + 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
